spi_apb_xfer: RTL and testbench

SPI_APB_XFER -- requirements
Module: spi_apb_xfer

---
 rtl/spi_apb_xfer.sv | 154 +++++++++++++++
 tb/tb_spi_apb_xfer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_xfer.sv
// APB master that runs one SPI byte exchange per request: write TXDATA,
// poll STATUS until RXRDY (or give up after MAX_POLLS reads), then read RXDATA.
module spi_apb_xfer #(
    parameter int         APB_DWIDTH  = 8,
    parameter logic [6:0] TXDATA_ADDR = 7'h0C,
    parameter logic [6:0] RXDATA_ADDR = 7'h08,
    parameter logic [6:0] STATUS_ADDR = 7'h04,
    parameter int         RXRDY_BIT   = 2,
    parameter int         MAX_POLLS   = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    input  logic [7:0]            req_data,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [6:0]            PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DWIDTH-1:0] PWDATA,
    input  logic [APB_DWIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_SETUP  = 3'd1,
        S_WR_ACCESS = 3'd2,
        S_ST_SETUP  = 3'd3,
        S_ST_ACCESS = 3'd4,
        S_RD_SETUP  = 3'd5,
        S_RD_ACCESS = 3'd6,
        S_RESP      = 3'd7
    } state_t;

    localparam logic [7:0] MAX_POLLS_C = 8'(MAX_POLLS);

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] polls_q, polls_d;
    logic [7:0] rdata_q, rdata_d;
    logic       timeout_q, timeout_d;
    logic [7:0] polls_inc;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            byte_q    <= 8'h00;
            polls_q   <= 8'h00;
            rdata_q   <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            polls_q   <= polls_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    // Saturating so the counter can never wrap back below MAX_POLLS.
    assign polls_inc = (polls_q == 8'hFF) ? polls_q : polls_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        polls_d   = polls_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    byte_d    = req_data;
                    polls_d   = 8'h00;
                    rdata_d   = 8'h00;
                    timeout_d = 1'b0;
                    state_d   = S_WR_SETUP;
                end
            end
            S_WR_SETUP:  state_d = S_WR_ACCESS;
            S_WR_ACCESS: if (PREADY) state_d = S_ST_SETUP;
            S_ST_SETUP:  state_d = S_ST_ACCESS;
            S_ST_ACCESS: begin
                if (PREADY) begin
                    if (PRDATA[RXRDY_BIT]) begin
                        state_d = S_RD_SETUP;
                    end else begin
                        polls_d = polls_inc;
                        if (polls_inc == MAX_POLLS_C) begin
                            timeout_d = 1'b1;
                            state_d   = S_RESP;
                        end else begin
                            state_d = S_ST_SETUP;
                        end
                    end
                end
            end
            S_RD_SETUP: state_d = S_RD_ACCESS;
            S_RD_ACCESS: begin
                if (PREADY) begin
                    rdata_d = PRDATA[7:0];
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only from registered state, so async reset clears them at once.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 8'h00;
        busy      = (state_q != S_IDLE);
        PADDR     = 7'h00;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PWDATA    = '0;
        case (state_q)
            S_IDLE: req_ready = !PRESET;
            S_WR_SETUP, S_WR_ACCESS: begin
                PADDR       = TXDATA_ADDR;
                PSEL        = 1'b1;
                PENABLE     = (state_q == S_WR_ACCESS);
                PWRITE      = 1'b1;
                PWDATA[7:0] = byte_q;
            end
            S_ST_SETUP, S_ST_ACCESS: begin
                PADDR   = STATUS_ADDR;
                PSEL    = 1'b1;
                PENABLE = (state_q == S_ST_ACCESS);
            end
            S_RD_SETUP, S_RD_ACCESS: begin
                PADDR   = RXDATA_ADDR;
                PSEL    = 1'b1;
                PENABLE = (state_q == S_RD_ACCESS);
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = timeout_q;
                rsp_data  = timeout_q ? 8'h00 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_apb_xfer.sv
// Randomized bench for spi_apb_xfer: an APB slave model plays the SPI core and
// a transaction-level model predicts the APB access list, latency and response.
module tb_spi_apb_xfer;

  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_err, busy;
  logic [7:0] rsp_data;
  logic [6:0] paddr;
  logic       psel, penable, pwrite, pready;
  logic [7:0] pwdata, prdata;

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration, written only by the main sequence
  int         cfg_clear;
  int         cfg_ws;
  logic [7:0] cfg_rx;

  // slave state, written only by the slave process
  int          st_reads;
  int          ws_cnt;
  logic [17:0] snap;
  logic [15:0] log_q[$];

  logic [15:0] exp_q[$];

  spi_apb_xfer #(.APB_DWIDTH(8), .MAX_POLLS(MAXP)) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] apb_vec();
    return {paddr, pwdata, psel, penable, pwrite};
  endfunction

  // APB slave: decides PREADY/PRDATA on the falling edge, logs completed accesses
  always @(negedge clk) begin
    if (rst) begin
      pready = 1'b1;
      st_reads = 0;
      ws_cnt = 0;
    end else if (psel && !penable && pwrite) begin
      st_reads = 0;
      ws_cnt = 0;
      log_q.delete();
      pready = 1'b1;
    end else if (psel && penable) begin
      if (pwrite && ws_cnt < cfg_ws) begin
        if (ws_cnt == 0) snap = apb_vec();
        else chk("apb_stable", 32'(apb_vec()), 32'(snap));
        pready = 1'b0;
        ws_cnt++;
      end else begin
        if (pwrite && cfg_ws > 0) chk("apb_stable_end", 32'(apb_vec()), 32'(snap));
        pready = 1'b1;
        if (paddr == 7'h04) begin
          prdata = 8'($urandom);
          prdata[2] = (st_reads >= cfg_clear);
          st_reads++;
        end else if (paddr == 7'h08) begin
          prdata = cfg_rx;
        end else begin
          prdata = 8'($urandom);
        end
        log_q.push_back({pwrite, paddr, pwdata});
      end
    end else begin
      pready = 1'b1;
      prdata = 8'($urandom);
    end
  end

  // One request; the expected access list, latency and response come from the
  // protocol: 2 cycles per APB access plus write wait states, RESP right after.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] rx,
                          input int clear_reads, input int ws);
    int polls, lat, n;
    bit ok, got_rsp;
    logic [7:0] exp_data;
    cfg_clear = clear_reads;
    cfg_ws = ws;
    cfg_rx = rx;
    ok = (clear_reads < MAXP);
    polls = ok ? clear_reads + 1 : MAXP;
    exp_data = ok ? rx : 8'h00;
    exp_q.delete();
    exp_q.push_back({1'b1, 7'h0C, tx});
    for (int i = 0; i < polls; i++) exp_q.push_back({1'b0, 7'h04, 8'h00});
    if (ok) exp_q.push_back({1'b0, 7'h08, 8'h00});

    @(negedge clk);
    req_valid = 1'b1;
    req_data = tx;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // a request offered while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_data = ~tx;
    got_rsp = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("busy_ready", {30'd0, busy, req_ready}, 32'd2);
      if (c == 3) req_valid = 1'b0;
      if (rsp_valid) begin
        lat = c;
        got_rsp = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    chk("rsp_seen", 32'(got_rsp), 32'd1);
    chk("latency", 32'(lat), 32'(2 + ws + 2 * polls + (ok ? 2 : 0)));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(rsp_err), 32'(!ok));
    chk("n_access", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("access%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
    @(posedge clk);
    #1;
    chk("after_rsp", {29'd0, rsp_valid, busy, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_data = 8'h00;
    pready = 1'b1;
    prdata = 8'h00;
    cfg_clear = 0;
    cfg_ws = 0;
    cfg_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rsp_valid, rsp_err, rsp_data, busy, paddr, psel, penable,
                          pwrite, pwdata, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {30'd0, req_ready, busy}, 32'd2);

    run_xfer(8'hA5, 8'h3C, 0, 0);   // basic exchange, 6-edge latency
    run_xfer(8'h5A, 8'hC3, 3, 0);   // RXRDY on the fourth poll
    run_xfer(8'h11, 8'h77, 99, 0);  // never ready: timeout after MAXP polls
    run_xfer(8'hE7, 8'h81, 0, 5);   // write held off by 5 wait states

    for (int k = 0; k < 10; k++)
      run_xfer(8'($urandom), 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3));

    // reset asserted in the middle of a status access
    cfg_clear = 99;
    cfg_ws = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_data = 8'h3E;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!(psel && penable && paddr == 7'h04) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_status", {31'd0, psel && penable && paddr == 7'h04}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", {rsp_valid, rsp_err, rsp_data, busy, paddr, psel, penable,
                        pwrite, pwdata, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", {30'd0, req_ready, busy}, 32'd2);
    run_xfer(8'h96, 8'h69, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
